// File: rtl/binary_mac_pkg.sv
// Shared types and constants for the signed MAC accumulator.
// Saturation bounds are derived from the accumulator width.
package binary_mac_pkg;

    localparam int PW_DEF = 13;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic longint sat_max(input int aw);
        return (64'sd1 <<< (aw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int aw);
        return -(64'sd1 <<< (aw - 1));
    endfunction

endpackage

// File: rtl/binary_sat_add.sv
// Signed AW-bit adder that clamps to the representable range.
// sat flags any clamp; usable by any accumulation stage.
module binary_sat_add
    import binary_mac_pkg::*;
#(
    parameter int AW = 20
) (
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    output logic signed [AW-1:0] sum,
    output logic                 sat
);

    localparam logic signed [AW-1:0] MAXV = AW'(sat_max(AW));
    localparam logic signed [AW-1:0] MINV = AW'(sat_min(AW));

    logic signed [AW:0] full;

    // Widen by one bit so the true sum never wraps, then clamp.
    always_comb begin
        full = {a[AW-1], a} + {b[AW-1], b};
        sat  = full[AW] ^ full[AW-1];
        sum  = full[AW-1:0];
        if (sat) sum = full[AW] ? MINV : MAXV;
    end

endmodule

// File: rtl/binary_mac_acc_7.sv
// Frame accumulator for signed multiplier products.
// Emits one saturated dot product per frame.
module binary_mac_acc_7
    import binary_mac_pkg::*;
#(
    parameter int PW  = PW_DEF,
    parameter int AW  = 20,
    parameter int LEN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [PW-1:0] in_prod,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_sum,
    output logic [7:0]           out_count,
    output logic                 out_ovf
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    state_t state_q, state_d;

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] sum;
    logic [7:0]           cnt_q;
    logic                 ovf_q;
    logic                 sat;
    logic                 ovf_n;
    logic                 beat;
    logic                 frame_end;
    logic                 close;

    assign prod_ext  = {{(AW-PW){in_prod[PW-1]}}, in_prod};
    assign in_ready  = (state_q == ACC) | out_ready;
    assign beat      = in_valid & in_ready;
    assign frame_end = in_last | (cnt_q == LAST_IDX);
    assign close     = beat & frame_end;
    assign ovf_n     = ovf_q | sat;
    assign out_valid = (state_q == HOLD);

    binary_sat_add #(
        .AW (AW)
    ) u_add (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (sum),
        .sat (sat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ACC;
        else     state_q <= state_d;
    end

    // Enter HOLD on a closing beat; leave it on a drain without a new close.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:  if (close) state_d = HOLD;
            HOLD: if (out_ready && !close) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Accumulate beats; a closing beat publishes the result and clears the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (beat) begin
            if (frame_end) begin
                out_sum   <= sum;
                out_count <= cnt_q + 8'd1;
                out_ovf   <= ovf_n;
                acc_q     <= '0;
                cnt_q     <= '0;
                ovf_q     <= 1'b0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + 8'd1;
                ovf_q <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_binary_mac_acc_7.sv
// Directed and randomized checks of the frame accumulator.
// Two instances: AW=14/LEN=4 and AW=20/LEN=1.
module tb_binary_mac_acc_7;

    logic clk;
    logic rst;

    logic               a_in_valid, a_in_ready, a_in_last;
    logic signed [12:0] a_in_prod;
    logic               a_out_valid, a_out_ready, a_out_ovf;
    logic signed [13:0] a_out_sum;
    logic [7:0]         a_out_count;

    logic               b_in_valid, b_in_ready, b_in_last;
    logic signed [12:0] b_in_prod;
    logic               b_out_valid, b_out_ready, b_out_ovf;
    logic signed [19:0] b_out_sum;
    logic [7:0]         b_out_count;

    int n_cmp = 0;
    int n_err = 0;

    binary_mac_acc_7 #(.PW(13), .AW(14), .LEN(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_prod   (a_in_prod),
        .in_last   (a_in_last),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_count (a_out_count),
        .out_ovf   (a_out_ovf)
    );

    binary_mac_acc_7 #(.PW(13), .AW(20), .LEN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_prod   (b_in_prod),
        .in_last   (b_in_last),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_count (b_out_count),
        .out_ovf   (b_out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_beat(input int p, input bit l);
        a_in_valid = 1'b1;
        a_in_prod  = 13'(p);
        a_in_last  = l;
        tick();
    endtask

    task automatic a_idle();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
        tick();
    endtask

    task automatic b_beat(input int p);
        b_in_valid = 1'b1;
        b_in_prod  = 13'(p);
        tick();
    endtask

    function automatic int clamp14(input int v, output bit s);
        s = 1'b0;
        if (v > 8191)  begin s = 1'b1; return 8191;  end
        if (v < -8192) begin s = 1'b1; return -8192; end
        return v;
    endfunction

    // Reference frame model for the randomized phase
    int m_acc, m_cnt, m_sum, m_count, p;
    bit m_ovf, m_pend, m_movf, s, exp_rdy, bt;

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_prod = 0; a_in_last = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_prod = 0; b_in_last = 0; b_out_ready = 0;
        tick();
        tick();
        chk("rst_valid", a_out_valid, 0);
        chk("rst_sum", a_out_sum, 0);
        chk("rst_count", a_out_count, 0);
        chk("rst_ovf", a_out_ovf, 0);
        chk("rst_ready", a_in_ready, 1);
        rst = 1'b0;

        a_out_ready = 1'b1;
        a_beat(100, 0);
        chk("basic_v1", a_out_valid, 0);
        a_beat(-50, 0);
        a_beat(4032, 0);
        chk("basic_v3", a_out_valid, 0);
        a_beat(-4032, 0);
        chk("basic_valid", a_out_valid, 1);
        chk("basic_sum", a_out_sum, 50);
        chk("basic_count", a_out_count, 4);
        chk("basic_ovf", a_out_ovf, 0);
        a_idle();
        chk("basic_drop", a_out_valid, 0);

        a_beat(-7, 0);
        a_beat(-9, 1);
        chk("early_valid", a_out_valid, 1);
        chk("early_sum", a_out_sum, -16);
        chk("early_count", a_out_count, 2);
        a_idle();
        chk("early_drop", a_out_valid, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        chk("early_next_v", a_out_valid, 0);
        a_beat(1, 0);
        chk("early_next_sum", a_out_sum, 4);
        chk("early_next_count", a_out_count, 4);
        a_idle();

        a_out_ready = 1'b0;
        a_beat(1, 0);
        a_beat(2, 0);
        a_beat(3, 0);
        a_beat(4, 0);
        chk("bp_valid", a_out_valid, 1);
        chk("bp_sum", a_out_sum, 10);
        a_in_valid = 1'b1;
        a_in_prod  = 13'sd7;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_ready", a_in_ready, 0);
            chk("bp_hold_valid", a_out_valid, 1);
            chk("bp_hold_sum", a_out_sum, 10);
            chk("bp_hold_count", a_out_count, 4);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", a_in_ready, 1);
        tick();
        chk("bp_drop", a_out_valid, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        chk("bp_next_valid", a_out_valid, 1);
        chk("bp_next_sum", a_out_sum, 10);
        chk("bp_next_count", a_out_count, 4);
        a_idle();

        a_beat(4032, 0);
        a_beat(4032, 0);
        a_beat(4032, 0);
        a_beat(-100, 0);
        chk("sat_sum", a_out_sum, 8091);
        chk("sat_ovf", a_out_ovf, 1);
        a_beat(1, 0);
        chk("sat_drain", a_out_valid, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        chk("sat_next_sum", a_out_sum, 4);
        chk("sat_next_ovf", a_out_ovf, 0);
        a_idle();

        a_beat(1000, 0);
        a_beat(1000, 0);
        a_beat(1000, 0);
        rst = 1'b1;
        a_idle();
        rst = 1'b0;
        chk("mrst_valid", a_out_valid, 0);
        chk("mrst_sum", a_out_sum, 0);
        chk("mrst_count", a_out_count, 0);
        chk("mrst_ovf", a_out_ovf, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        a_beat(1, 0);
        chk("mrst_next_sum", a_out_sum, 4);
        chk("mrst_next_count", a_out_count, 4);
        a_idle();

        b_out_ready = 1'b1;
        for (int i = 5; i <= 7; i++) begin
            b_beat(i);
            chk("len1_valid", b_out_valid, 1);
            chk("len1_sum", b_out_sum, i);
            chk("len1_count", b_out_count, 1);
        end
        b_in_valid = 1'b0;
        tick();
        chk("len1_drop", b_out_valid, 0);

        m_acc = 0; m_cnt = 0; m_ovf = 0; m_pend = 0;
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = ($urandom % 4) != 0;
            a_in_prod   = 13'($urandom);
            a_in_last   = ($urandom % 5) == 0;
            a_out_ready = ($urandom % 3) != 0;
            #1;
            exp_rdy = !m_pend || a_out_ready;
            chk("rnd_ready", a_in_ready, exp_rdy);
            bt = a_in_valid && exp_rdy;
            if (m_pend && a_out_ready) m_pend = 0;
            if (bt) begin
                p = a_in_prod;
                m_acc = clamp14(m_acc + p, s);
                m_ovf = m_ovf | s;
                m_cnt++;
                if (a_in_last || m_cnt == 4) begin
                    m_sum = m_acc; m_count = m_cnt; m_movf = m_ovf;
                    m_pend = 1; m_acc = 0; m_cnt = 0; m_ovf = 0;
                end
            end
            tick();
            chk("rnd_valid", a_out_valid, m_pend);
            if (m_pend) begin
                chk("rnd_sum", a_out_sum, m_sum);
                chk("rnd_count", a_out_count, m_count);
                chk("rnd_ovf", a_out_ovf, m_movf);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
